spi_debug_sequencer: RTL
========================

SPI_DEBUG_SEQUENCER -- requirements
Module: spi_debug_sequencer

Interface
REQ-001 SHALL have parameter NB_BITS, default 32: data word width.
REQ-002 SHALL have parameter NB_REG, default 5: register index width.
REQ-003 SHALL have parameter HALT_WAIT, default 2: drain cycles before first read, range 1..15.
REQ-004 SHALL have port i_clock, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port i_reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port i_cmd_valid, input, 1: one-cycle command strobe from SPI slave.
REQ-007 SHALL have port i_cmd_code, input, 2: command code; 00 abort, 01 dump all, 10 registers only, 11 latch only.
REQ-008 SHALL have port i_word_data, input, NB_BITS: selected word returned by decode interface.
REQ-009 SHALL have port i_tx_ready, input, 1: SPI slave accepts o_tx_data this cycle.
REQ-010 SHALL have port o_req, output, NB_BITS: request word; [22:21] latch word select, [20:16] register index, other bits 0.
REQ-011 SHALL have port o_in_use, output, 1: debug ownership of register-file read port.
REQ-012 SHALL have port o_halt, output, 1: pipeline stall request.
REQ-013 SHALL have port o_tx_data, output, NB_BITS: registered word to SPI slave.
REQ-014 SHALL have port o_tx_valid, output, 1: o_tx_data valid.
REQ-015 SHALL have port o_busy, output, 1: state not IDLE.
REQ-016 SHALL have port o_done, output, 1: one-cycle pulse at normal dump completion.

Function
REQ-017 SHALL implement states IDLE, HALT, SEL, SEND, DONE.
REQ-018 IDLE: i_cmd_valid with code 01/10/11 SHALL latch mode, assert o_halt, load drain counter HALT_WAIT-1, go HALT; code 00 ignored.
REQ-019 HALT: counter decrements each cycle; at 0 SHALL go SEL with index set to first item of mode.
REQ-020 Item order: registers 1..31 (index in o_req[20:16], [22:21]=00), then latch words 00,01,10,11 (o_req[20:16]=0); mode 10 = registers only, 11 = latch only.
REQ-021 SEL: o_req driven from current item; next edge SHALL capture i_word_data into o_tx_data, set o_tx_valid, go SEND (one cycle read latency).
REQ-022 SEND: o_tx_data and o_tx_valid SHALL hold stable until i_tx_ready high; on that edge clear o_tx_valid, advance item, go SEL, or DONE if last item.
REQ-023 DONE: o_done high exactly one cycle, o_halt and o_in_use deassert, next state IDLE.
REQ-024 o_in_use SHALL be high in SEL and SEND only; o_halt high in HALT, SEL, SEND.
REQ-025 Register index SHALL never be 0 in register phase; counter stops at 31 without wrap.
REQ-026 i_cmd_valid with code 00 in any non-IDLE state SHALL go IDLE next edge, clear o_tx_valid, o_halt, o_in_use, without o_done pulse; abort wins over simultaneous i_tx_ready.
REQ-027 Non-abort commands while o_busy high SHALL be ignored.
REQ-028 o_req SHALL be all-zero outside SEL and SEND.

Reset
REQ-029 i_reset high SHALL force IDLE immediately; o_req, o_tx_data = 0; o_tx_valid, o_in_use, o_halt, o_busy, o_done = 0; counters = 0.
REQ-030 Reset mid-dump SHALL discard progress; next command restarts from first item.

Configuration
REQ-031 Macro DUMP_CHECKSUM_EN defined: after last item, SHALL send one extra word = XOR of all words sent in this dump (o_req all-zero during it), then DONE.
REQ-032 Macro undefined: no checksum word, no accumulator logic; DONE follows last item.

Verification
REQ-033 Cmd 01, HALT_WAIT=2, i_tx_ready always 1 -> 35 words: regs 1..31 then latch 0..3, o_done once, first o_tx_valid 4 cycles after strobe.
REQ-034 Cmd 11, i_tx_ready held low 5 cycles on word 2 -> o_tx_data constant during stall, 4 words total, order 00,01,10,11.
REQ-035 Cmd 01, abort (code 00) at word 10 concurrent with i_tx_ready -> IDLE next cycle, no o_done, o_halt 0.
REQ-036 Cmd 10 issued, cmd 11 during dump -> ignored, exactly 31 words, o_req[22:21]=00 throughout.
REQ-037 DUMP_CHECKSUM_EN, cmd 11, latch words 0x1,0x2,0x4,0x8 -> fifth word 0x0000000F.
REQ-038 Async i_reset pulse mid-SEND -> all outputs 0 before next clock edge; next cmd 01 starts at register 1.

Source files
------------

// File: rtl/spi_debug_sequencer.sv
// Debug dump sequencer: halts the pipeline, walks registers 1..31 and/or latch words 0..3 through
// the decode interface and streams each word to the SPI slave. Optional macro: DUMP_CHECKSUM_EN.
module spi_debug_sequencer #(
  parameter int unsigned NB_BITS   = 32,
  parameter int unsigned NB_REG    = 5,
  parameter int unsigned HALT_WAIT = 2
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  input  logic [1:0]         i_cmd_code,
  input  logic [NB_BITS-1:0] i_word_data,
  input  logic               i_tx_ready,
  output logic [NB_BITS-1:0] o_req,
  output logic               o_in_use,
  output logic               o_halt,
  output logic [NB_BITS-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [2:0] {StIdle, StHalt, StSel, StSend, StDone} state_e;
  typedef enum logic [1:0] {PhReg, PhLatch, PhSum} phase_e;

  localparam logic [3:0]        DrainInit = 4'(HALT_WAIT - 1);
  localparam logic [NB_REG-1:0] LastReg   = '1;

  state_e               state_q, state_d;
  phase_e               phase_q, phase_d;
  logic [1:0]           mode_q, mode_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [NB_REG-1:0]    idx_q, idx_d;
  logic [1:0]           sel_q, sel_d;
  logic [NB_BITS-1:0]   tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 last_item;
  logic                 abort;
`ifdef DUMP_CHECKSUM_EN
  logic [NB_BITS-1:0]   sum_q, sum_d;
`endif

  assign abort = i_cmd_valid && (i_cmd_code == 2'b00);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sel_d      = sel_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    last_item  = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (i_cmd_valid && (i_cmd_code != 2'b00)) begin
          mode_d  = i_cmd_code;
          cnt_d   = DrainInit;
          state_d = StHalt;
        end
      end
      StHalt: begin
        if (cnt_q == 4'd0) begin
          state_d = StSel;
          phase_d = (mode_q == 2'b11) ? PhLatch : PhReg;
          idx_d   = NB_REG'(1);
          sel_d   = 2'b00;
`ifdef DUMP_CHECKSUM_EN
          sum_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StSel: begin
`ifdef DUMP_CHECKSUM_EN
        if (phase_q == PhSum) begin
          tx_data_d = sum_q;
        end else begin
          tx_data_d = i_word_data;
          sum_d     = sum_q ^ i_word_data;
        end
`else
        tx_data_d = i_word_data;
`endif
        tx_valid_d = 1'b1;
        state_d    = StSend;
      end
      StSend: begin
        if (i_tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = StSel;
          unique case (phase_q)
            PhReg: begin
              // Index saturates at the last register; latch phase ignores it.
              if (idx_q == LastReg) begin
                if (mode_q == 2'b10) begin
                  last_item = 1'b1;
                end else begin
                  phase_d = PhLatch;
                  sel_d   = 2'b00;
                end
              end else begin
                idx_d = idx_q + NB_REG'(1);
              end
            end
            PhLatch: begin
              if (sel_q == 2'b11) begin
                last_item = 1'b1;
              end else begin
                sel_d = sel_q + 2'b01;
              end
            end
            default: state_d = StDone;
          endcase
          if (last_item) begin
`ifdef DUMP_CHECKSUM_EN
            phase_d = PhSum;
`else
            state_d = StDone;
`endif
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort beats a simultaneous handshake and never produces a done pulse.
    if (abort && (state_q != StIdle)) begin
      state_d    = StIdle;
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      phase_q    <= PhReg;
      mode_q     <= 2'b00;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      sel_q      <= 2'b00;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

`ifdef DUMP_CHECKSUM_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  always_comb begin
    o_req = '0;
    if ((state_q == StSel) || (state_q == StSend)) begin
      if (phase_q == PhReg) begin
        o_req[16 +: NB_REG] = idx_q;
      end else if (phase_q == PhLatch) begin
        o_req[22:21] = sel_q;
      end
    end
  end

  assign o_in_use   = (state_q == StSel) || (state_q == StSend);
  assign o_halt     = (state_q == StHalt) || o_in_use;
  assign o_busy     = (state_q != StIdle);
  assign o_done     = (state_q == StDone);
  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;

endmodule
